// File: rtl/regfile_sequencer.sv
// Operand sequencer between instruction decode and execute: reads sources from the
// register file, tracks outstanding writes with a pending mask, bypasses writeback data.
module regfile_sequencer #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [BITS_ADDR-1:0] rs1,
   input  logic [BITS_ADDR-1:0] rs2,
   input  logic [BITS_ADDR-1:0] rd,
   input  logic                 rd_en,
   output logic [BITS_ADDR-1:0] rf_raddr1,
   output logic [BITS_ADDR-1:0] rf_raddr2,
   input  logic [BITS_DATA-1:0] rf_rdata1,
   input  logic [BITS_DATA-1:0] rf_rdata2,
   output logic                 rf_we,
   output logic [BITS_ADDR-1:0] rf_waddr,
   output logic [BITS_DATA-1:0] rf_wdata,
   input  logic                 wb_valid,
   input  logic [BITS_ADDR-1:0] wb_addr,
   input  logic [BITS_DATA-1:0] wb_data,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [BITS_DATA-1:0] op_a,
   output logic [BITS_DATA-1:0] op_b,
   output logic [BITS_ADDR-1:0] op_rd,
   output logic                 op_rd_en
);

   // state   | meaning
   // S_IDLE  | waiting for an instruction, instr_ready high
   // S_CHECK | reading sources; stalls while any used register has a write outstanding
   // S_ISSUE | operands held on op_* until execute takes them
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   localparam int NUM_REGS = 2 ** BITS_ADDR;

   state_t                state;
   state_t                state_nxt;
   logic [NUM_REGS-1:0]   pending;
   logic [NUM_REGS-1:0]   pending_nxt;
   logic [NUM_REGS-1:0]   pending_clr;
   logic [NUM_REGS-1:0]   wb_mask;
   logic [NUM_REGS-1:0]   set_mask;
   logic [BITS_ADDR-1:0]  rs1_q;
   logic [BITS_ADDR-1:0]  rs2_q;
   logic [BITS_ADDR-1:0]  rd_q;
   logic                  rd_en_q;
   logic                  stall;
   logic                  take;
   logic                  accept;
   logic [BITS_DATA-1:0]  src_a;
   logic [BITS_DATA-1:0]  src_b;

   assign rf_we    = wb_valid;
   assign rf_waddr = wb_addr;
   assign rf_wdata = wb_data;

   // Writeback clears before the stall test; a same-cycle issue to that register re-sets it.
   assign wb_mask     = wb_valid ? (NUM_REGS'(1) << wb_addr) : '0;
   assign pending_clr = pending & ~wb_mask;
   assign stall       = pending_clr[rs1_q] | pending_clr[rs2_q] | (rd_en_q & pending_clr[rd_q]);
   assign take        = (state == S_CHECK) && !stall;
   assign set_mask    = (take && rd_en_q) ? (NUM_REGS'(1) << rd_q) : '0;
   assign pending_nxt = pending_clr | set_mask;

   assign src_a = (wb_valid && (wb_addr == rs1_q)) ? wb_data : rf_rdata1;
   assign src_b = (wb_valid && (wb_addr == rs2_q)) ? wb_data : rf_rdata2;

   assign accept = (state == S_IDLE) && instr_valid;

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      op_valid    = 1'b0;
      rf_raddr1   = '0;
      rf_raddr2   = '0;
      case (state)
         S_IDLE: begin
            instr_ready = !rst;
            if (instr_valid) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            rf_raddr1 = rs1_q;
            rf_raddr2 = rs2_q;
            if (!stall) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            op_valid = 1'b1;
            if (op_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pending  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         rd_en_q  <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
         op_rd_en <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         if (accept) begin
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            rd_en_q <= rd_en;
         end
         if (take) begin
            op_a     <= src_a;
            op_b     <= src_b;
            op_rd    <= rd_q;
            op_rd_en <= rd_en_q;
         end
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: cycle-level reference model, directed scenarios with
// literal expectations, then randomized traffic compared every cycle.
module tb_regfile_sequencer;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  rs1, rs2, rd;
   logic        rd_en;
   logic [2:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [31:0] wb_data;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a, op_b;
   logic [2:0]  op_rd;
   logic        op_rd_en;

   logic [31:0] regs [8];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase 0 = waiting, 1 = reading sources, 2 = offering operands
   int          m_phase;
   bit [7:0]    m_pend;
   bit [2:0]    m_rs1, m_rs2, m_rd;
   bit          m_rden;
   bit [31:0]   m_op_a, m_op_b;
   bit [2:0]    m_op_rd;
   bit          m_op_rden;

   regfile_sequencer #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rd_en(rd_en),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en)
   );

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("instr_ready", 32'(instr_ready), 32'(m_phase == 0 && !rst));
      chk("rf_raddr1",   32'(rf_raddr1),   (m_phase == 1) ? 32'(m_rs1) : 32'd0);
      chk("rf_raddr2",   32'(rf_raddr2),   (m_phase == 1) ? 32'(m_rs2) : 32'd0);
      chk("rf_we",       32'(rf_we),       32'(wb_valid));
      chk("rf_waddr",    32'(rf_waddr),    32'(wb_addr));
      chk("rf_wdata",    rf_wdata,         wb_data);
      chk("op_valid",    32'(op_valid),    32'(m_phase == 2));
      chk("op_a",        op_a,             m_op_a);
      chk("op_b",        op_b,             m_op_b);
      chk("op_rd",       32'(op_rd),       32'(m_op_rd));
      chk("op_rd_en",    32'(op_rd_en),    32'(m_op_rden));
      chk("pending",     32'(dut.pending), 32'(m_pend));
   endtask

   // Called just after a rising edge with the inputs that edge sampled; regs still hold
   // their pre-edge contents, so source reads see what the DUT saw.
   task automatic model_update();
      bit [7:0]  pc;
      bit [31:0] a, b;
      if (rst) begin
         m_phase = 0; m_pend = '0;
         m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rden = 1'b0;
         m_op_a = '0; m_op_b = '0; m_op_rd = '0; m_op_rden = 1'b0;
      end else begin
         pc = m_pend;
         if (wb_valid) pc[wb_addr] = 1'b0;
         case (m_phase)
            0: if (instr_valid) begin
                  m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_rden = rd_en;
                  m_phase = 1;
               end
            1: if (!(pc[m_rs1] || pc[m_rs2] || (m_rden && pc[m_rd]))) begin
                  a = (wb_valid && wb_addr == m_rs1) ? wb_data : regs[m_rs1];
                  b = (wb_valid && wb_addr == m_rs2) ? wb_data : regs[m_rs2];
                  m_op_a = a; m_op_b = b; m_op_rd = m_rd; m_op_rden = m_rden;
                  if (m_rden) pc[m_rd] = 1'b1;
                  m_phase = 2;
               end
            default: if (op_ready) m_phase = 0;
         endcase
         m_pend = pc;
      end
      if (wb_valid) regs[wb_addr] = wb_data;
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
      model_update();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = $urandom;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      rst = 1'b1; instr_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; rd_en = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
      @(posedge clk);
      #1;
      model_update();
      step();
      chk("reset instr_ready", 32'(instr_ready), 32'd0);
      chk("reset op_valid",    32'(op_valid),    32'd0);
      chk("reset pending",     32'(dut.pending), 32'd0);
      chk("reset op_a",        op_a,             32'd0);

      // first instruction: R1+R2 sources, writes R3
      rst = 1'b0;
      instr_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd3; rd_en = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("t1 instr_ready busy", 32'(instr_ready), 32'd0);
      chk("t1 op_valid early",   32'(op_valid),    32'd0);
      step();
      chk("t2 op_valid", 32'(op_valid),    32'd1);
      chk("t2 op_a",     op_a,             32'd5);
      chk("t2 op_b",     op_b,             32'd7);
      chk("t2 op_rd",    32'(op_rd),       32'd3);
      chk("t2 op_rd_en", 32'(op_rd_en),    32'd1);
      chk("t2 pending",  32'(dut.pending), 32'h08);
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      chk("t3 instr_ready", 32'(instr_ready), 32'd1);
      chk("t3 op_valid",    32'(op_valid),    32'd0);

      // hazard on R3 resolved by a same-cycle writeback with bypass
      instr_valid = 1'b1; rs1 = 3'd3; rs2 = 3'd1; rd = 3'd5; rd_en = 1'b0;
      step();
      instr_valid = 1'b0;
      step();
      chk("stall op_valid",  32'(op_valid),  32'd0);
      chk("stall rf_raddr1", 32'(rf_raddr1), 32'd3);
      wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 32'hAB;
      step();
      wb_valid = 1'b0;
      chk("bypass op_valid", 32'(op_valid),    32'd1);
      chk("bypass op_a",     op_a,             32'hAB);
      chk("bypass op_b",     op_b,             32'd5);
      chk("bypass pending",  32'(dut.pending), 32'd0);

      // backpressure holds operands
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold op_valid", 32'(op_valid), 32'd1);
         chk("hold op_a",     op_a,          32'hAB);
      end
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      chk("release op_valid",    32'(op_valid),    32'd0);
      chk("release instr_ready", 32'(instr_ready), 32'd1);

      // set and clear of the same bit in one cycle: set wins
      instr_valid = 1'b1; rs1 = 3'd0; rs2 = 3'd0; rd = 3'd4; rd_en = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
      chk("rd4 pending", 32'(dut.pending), 32'h10);
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      instr_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd4; rd_en = 1'b1;
      step();
      instr_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 32'h44;
      step();
      wb_valid = 1'b0;
      chk("setwin pending",  32'(dut.pending), 32'h10);
      chk("setwin op_valid", 32'(op_valid),    32'd1);
      chk("setwin op_rd",    32'(op_rd),       32'd4);
      chk("setwin op_a",     op_a,             32'd5);

      // reset while offering operands
      rst = 1'b1;
      step();
      chk("rst op_valid",    32'(op_valid),    32'd0);
      chk("rst pending",     32'(dut.pending), 32'd0);
      chk("rst instr_ready", 32'(instr_ready), 32'd0);
      chk("rst op_a",        op_a,             32'd0);
      rst = 1'b0;
      #1;
      chk("post rst instr_ready", 32'(instr_ready), 32'd1);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 149) == 0);
         instr_valid = 1'($urandom_range(0, 1));
         rs1         = 3'($urandom_range(0, 7));
         rs2         = 3'($urandom_range(0, 7));
         rd          = 3'($urandom_range(0, 7));
         rd_en       = 1'($urandom_range(0, 1));
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_addr     = 3'($urandom_range(0, 7));
         wb_data     = $urandom;
         op_ready    = 1'($urandom_range(0, 1));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter BITS_DATA, default 32, register data width; SHALL match the register file.
REQ-002 Parameter BITS_ADDR, default 3, register address width; SHALL address 2**BITS_ADDR registers.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 instr_valid  in  1  decoded instruction offered.
REQ-006 instr_ready  out  1  sequencer accepts the instruction.
REQ-007 rs1, rs2  in  BITS_ADDR each  source register addresses.
REQ-008 rd  in  BITS_ADDR  destination address; rd_en  in  1  the instruction writes rd.
REQ-009 rf_raddr1, rf_raddr2  out  BITS_ADDR each  register-file read addresses.
REQ-010 rf_rdata1, rf_rdata2  in  BITS_DATA each  combinational read data, valid in the same cycle.
REQ-011 rf_we  out  1, rf_waddr  out  BITS_ADDR, rf_wdata  out  BITS_DATA  register-file write port.
REQ-012 wb_valid  in  1, wb_addr  in  BITS_ADDR, wb_data  in  BITS_DATA  writeback from the execute stage.
REQ-013 op_valid  out  1, op_ready  in  1  operand handshake toward execute.
REQ-014 op_a, op_b  out  BITS_DATA; op_rd  out  BITS_ADDR; op_rd_en  out  1  issued operands.

Function
REQ-015 The write port SHALL be a combinational pass-through: rf_we=wb_valid, rf_waddr=wb_addr, rf_wdata=wb_data, in every state.
REQ-016 The block SHALL keep a 2**BITS_ADDR-bit pending mask; bit n set means a write to register n is outstanding.
REQ-017 The FSM SHALL have three states: IDLE, CHECK, ISSUE.
REQ-018 IDLE: instr_ready=1. On instr_valid, latch rs1/rs2/rd/rd_en and go to CHECK.
REQ-019 CHECK: instr_ready=0; rf_raddr1/2 SHALL drive the latched rs1/rs2. All other states SHALL drive them to 0.
REQ-020 CHECK SHALL stall, remaining in CHECK, if pending[rs1], pending[rs2], or (rd_en and pending[rd]) is set after this cycle's writeback clear.
REQ-021 A writeback in the same cycle SHALL clear its pending bit before the stall test. A source matching wb_addr with wb_valid=1 SHALL take wb_data instead of rf_rdata (bypass).
REQ-022 When CHECK does not stall, it SHALL register op_a/op_b, op_rd=rd, op_rd_en=rd_en, set pending[rd] if rd_en, and go to ISSUE.
REQ-023 ISSUE: op_valid=1. op_a, op_b, op_rd and op_rd_en SHALL stay stable until op_ready=1, then the FSM returns to IDLE.
REQ-024 Minimum latency: instruction accepted at edge t, op_valid=1 from edge t+2.
REQ-025 A writeback SHALL clear pending[wb_addr] in any state. A writeback to a non-pending register SHALL leave the mask unchanged. When set and clear target the same bit in the same cycle, the set SHALL win.
REQ-026 At most one instruction SHALL be in flight inside the block. instr_ready SHALL be 0 in CHECK and ISSUE.
REQ-027 Addresses SHALL use full BITS_ADDR width with no wrap-around logic. Register 0 is an ordinary register.

Reset
REQ-028 When rst=1 at an edge: state=IDLE, pending=0, op_valid=0, op_a=op_b=0, op_rd=0, op_rd_en=0, latched fields=0.
REQ-029 instr_ready SHALL be 0 while rst=1.
REQ-030 Reset in CHECK or ISSUE SHALL discard the in-flight instruction without issuing it. rf_we SHALL still follow wb_valid during reset.

Verification
REQ-031 Reset, then rs1=1, rs2=2, rd=3, rd_en=1, with R1=5 and R2=7 -> op_valid at t+2, op_a=5, op_b=7, op_rd=3, pending=0x08.
REQ-032 Next instruction with rs1=3 while pending[3]=1 -> stays in CHECK, op_valid=0; wb_valid with wb_addr=3 and wb_data=0xAB -> same cycle op_a=0xAB captured, ISSUE next cycle.
REQ-033 op_ready held 0 for 4 cycles in ISSUE -> op_valid=1 and operands constant; op_ready=1 -> IDLE, instr_ready=1 the next cycle.
REQ-034 Issue with rd=4, then a CHECK issuing rd=4 while wb_addr=4 arrives the same cycle -> pending[4] remains 1 (set wins).
REQ-035 rst=1 asserted in ISSUE -> next cycle op_valid=0, pending=0, instr_ready=1 after rst deasserts.
